// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared rename-stage sizes, register id types and free-list pointer helpers
package common;

    localparam int FETCH_WIDTH = 2;
    localparam int FREE_WIDTH  = 2;
    localparam int NUM_PREG    = 64;
    localparam int NUM_CREG    = 32;

    localparam int PREG_W      = $clog2(NUM_PREG);
    localparam int CREG_W      = $clog2(NUM_CREG);

    localparam int FL_DEPTH    = NUM_PREG - NUM_CREG;
    localparam int FL_PTR_W    = $clog2(FL_DEPTH) + 1;
    localparam int FL_IDX_W    = FL_PTR_W - 1;

    typedef logic [PREG_W-1:0]   preg_addr_t;
    typedef logic [CREG_W-1:0]   creg_addr_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;
    typedef logic [FL_IDX_W-1:0] fl_idx_t;

    typedef struct packed {
        logic       valid;
        preg_addr_t id;
    } pdst_t;

    // The wrap bit only matters for full/empty; storage is indexed by the low bits.
    function automatic fl_idx_t fl_idx(input fl_ptr_t p);
        return p[FL_IDX_W-1:0];
    endfunction

    function automatic fl_ptr_t count_ones_free(input logic [FREE_WIDTH-1:0] v);
        fl_ptr_t c;
        c = '0;
        for (int i = 0; i < FREE_WIDTH; i++) begin
            c = c + FL_PTR_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/free_list_prefix_count.sv
// rtl/free_list_prefix_count.sv - exclusive prefix popcount per bit plus total popcount
module fl_prefix_count #(
    parameter int N  = 2,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]         bits_in,
    output logic [N-1:0][CW-1:0] prefix,
    output logic [CW-1:0]        total
);

    always_comb begin
        total = '0;
        for (int i = 0; i < N; i++) begin
            prefix[i] = total;
            total     = total + CW'(bits_in[i]);
        end
    end

endmodule

// File: rtl/free_list.sv
// rtl/free_list.sv - circular physical-register free list with speculative head and flush rollback
module free_list
    import common::*;
(
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [FETCH_WIDTH-1:0]            alloc_req,
    input  logic                              alloc_en,
    output logic                              alloc_ready,
    output pdst_t [FETCH_WIDTH-1:0]           pdst_fl,
    input  logic [FREE_WIDTH-1:0]             free_valid,
    input  preg_addr_t [FREE_WIDTH-1:0]       free_id,
    input  logic [FREE_WIDTH-1:0]             commit_alloc,
    input  logic                              flush,
    output fl_ptr_t                           free_count
);

    localparam int AW = $clog2(FETCH_WIDTH + 1);
    localparam int FW = $clog2(FREE_WIDTH + 1);

    fl_ptr_t    head_q, head_d;
    fl_ptr_t    tail_q, tail_d;
    fl_ptr_t    commit_head_q, commit_head_d;
    preg_addr_t entries_q [FL_DEPTH];
    preg_addr_t entries_d [FL_DEPTH];

    logic [FETCH_WIDTH-1:0][AW-1:0] alloc_off;
    logic [AW-1:0]                  alloc_total;
    logic [FREE_WIDTH-1:0][FW-1:0]  free_off;
    logic [FW-1:0]                  free_total;
    fl_ptr_t                        commit_total;
    logic                           fire;

    fl_prefix_count #(.N(FETCH_WIDTH)) u_alloc_prefix (
        .bits_in (alloc_req),
        .prefix  (alloc_off),
        .total   (alloc_total)
    );

    fl_prefix_count #(.N(FREE_WIDTH)) u_free_prefix (
        .bits_in (free_valid),
        .prefix  (free_off),
        .total   (free_total)
    );

    assign free_count   = tail_q - head_q;
    assign alloc_ready  = free_count >= FL_PTR_W'(alloc_total);
    assign commit_total = count_ones_free(commit_alloc);

    // Slot i takes the entry after all lower-numbered requesting slots.
    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            pdst_fl[i] = '0;
            if (alloc_req[i]) begin
                pdst_fl[i].valid = alloc_ready;
                pdst_fl[i].id    = entries_q[fl_idx(head_q + FL_PTR_W'(alloc_off[i]))];
            end
        end
    end

    always_comb begin
        fire          = alloc_en & alloc_ready & ~flush;
        commit_head_d = commit_head_q + commit_total;
        head_d        = head_q;
        if (flush) begin
            head_d = commit_head_d;
        end else if (fire) begin
            head_d = head_q + FL_PTR_W'(alloc_total);
        end
        tail_d = tail_q + FL_PTR_W'(free_total);
    end

    // Returned ids are packed densely in port order starting at the tail.
    always_comb begin
        entries_d = entries_q;
        for (int j = 0; j < FREE_WIDTH; j++) begin
            if (free_valid[j]) begin
                entries_d[fl_idx(tail_q + FL_PTR_W'(free_off[j]))] = free_id[j];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q        <= '0;
            commit_head_q <= '0;
            tail_q        <= FL_PTR_W'(FL_DEPTH);
            for (int k = 0; k < FL_DEPTH; k++) begin
                entries_q[k] <= PREG_W'(NUM_CREG + k);
            end
        end else begin
            head_q        <= head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            entries_q     <= entries_d;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - self-checking bench for free_list against a queue-based model
module tb_free_list;
    import common::*;

    logic                        clk = 1'b0;
    logic                        resetn;
    logic [FETCH_WIDTH-1:0]      alloc_req;
    logic                        alloc_en;
    logic                        alloc_ready;
    pdst_t [FETCH_WIDTH-1:0]     pdst_fl;
    logic [FREE_WIDTH-1:0]       free_valid;
    preg_addr_t [FREE_WIDTH-1:0] free_id;
    logic [FREE_WIDTH-1:0]       commit_alloc;
    logic                        flush;
    fl_ptr_t                     free_count;

    always #5 clk = ~clk;

    free_list dut (
        .clk          (clk),
        .resetn       (resetn),
        .alloc_req    (alloc_req),
        .alloc_en     (alloc_en),
        .alloc_ready  (alloc_ready),
        .pdst_fl      (pdst_fl),
        .free_valid   (free_valid),
        .free_id      (free_id),
        .commit_alloc (commit_alloc),
        .flush        (flush),
        .free_count   (free_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // fl_q: allocatable ids in hand-out order; spec_q: allocated, not yet committed;
    // used_q: committed mappings (initially the architectural ids 0..31).
    int fl_q[$];
    int spec_q[$];
    int used_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_slot(input string name, input int i, input int v, input int id);
        chk({name, "_valid"}, int'(pdst_fl[i].valid), v);
        chk({name, "_id"}, int'(pdst_fl[i].id), id);
    endtask

    task automatic model_reset();
        fl_q.delete();
        spec_q.delete();
        used_q.delete();
        for (int k = 0; k < FL_DEPTH; k++) fl_q.push_back(NUM_CREG + k);
        for (int k = 0; k < NUM_CREG; k++) used_q.push_back(k);
    endtask

    task automatic drive(input logic [1:0] req, input logic en, input logic [1:0] fv,
                         input int id0, input int id1, input logic [1:0] ca, input logic fl);
        alloc_req    = req;
        alloc_en     = en;
        free_valid   = fv;
        free_id[0]   = id0[PREG_W-1:0];
        free_id[1]   = id1[PREG_W-1:0];
        commit_alloc = ca;
        flush        = fl;
    endtask

    // Asynchronous pulse in the middle of a cycle, released before the next edge.
    task automatic do_reset();
        drive(2'b00, 1'b0, 2'b00, 0, 0, 2'b00, 1'b0);
        resetn = 1'b0;
        #2;
        chk("async_reset_count", int'(free_count), FL_DEPTH);
        model_reset();
        resetn = 1'b1;
    endtask

    // Compare combinational outputs mid-cycle, then advance the model across the edge.
    task automatic cycle();
        int  cnt, nreq, nf, nc, off;
        bit  ready;
        @(negedge clk);
        cnt   = fl_q.size();
        nreq  = $countones(alloc_req);
        nf    = $countones(free_valid);
        nc    = $countones(commit_alloc);
        ready = (cnt >= nreq);

        assert (cnt + nf <= FL_DEPTH) else $error("free port overrun: count %0d plus %0d", cnt, nf);
        assert (nc <= spec_q.size()) else $error("commit_head would pass head");
        for (int j = 0; j < FREE_WIDTH; j++)
            if (free_valid[j]) assert (int'(free_id[j]) < NUM_PREG) else $error("free_id out of range");

        chk("free_count", int'(free_count), cnt);
        chk("alloc_ready", int'(alloc_ready), int'(ready));
        off = 0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (alloc_req[i]) begin
                chk("slot_valid", int'(pdst_fl[i].valid), int'(ready));
                if (off < cnt) chk("slot_id", int'(pdst_fl[i].id), fl_q[off]);
                off++;
            end else begin
                chk("idle_slot_valid", int'(pdst_fl[i].valid), 0);
                chk("idle_slot_id", int'(pdst_fl[i].id), 0);
            end
        end

        for (int c = 0; c < nc; c++) used_q.push_back(spec_q.pop_front());
        if (flush) begin
            while (spec_q.size() > 0) fl_q.push_front(spec_q.pop_back());
        end else if (alloc_en && ready) begin
            for (int c = 0; c < nreq; c++) spec_q.push_back(fl_q.pop_front());
        end
        for (int j = 0; j < FREE_WIDTH; j++) begin
            if (free_valid[j]) begin
                int idx[$];
                fl_q.push_back(int'(free_id[j]));
                idx = used_q.find_first_index(x) with (x == int'(free_id[j]));
                if (idx.size() > 0) used_q.delete(idx[0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        drive(2'b00, 1'b0, 2'b00, 0, 0, 2'b00, 1'b0);
        @(posedge clk);
        #1;

        // 1: two full-width allocations
        do_reset();
        drive(2'b11, 1'b1, 2'b00, 0, 0, 2'b00, 1'b0);
        #1;
        chk("t1_count0", int'(free_count), 32);
        chk("t1_ready0", int'(alloc_ready), 1);
        chk_slot("t1_a0", 0, 1, 32);
        chk_slot("t1_a1", 1, 1, 33);
        cycle();
        chk("t1_count1", int'(free_count), 30);
        chk_slot("t1_b0", 0, 1, 34);
        chk_slot("t1_b1", 1, 1, 35);
        cycle();
        chk("t1_count2", int'(free_count), 28);

        // 2: only slot 1 requests
        do_reset();
        drive(2'b10, 1'b1, 2'b00, 0, 0, 2'b00, 1'b0);
        #1;
        chk_slot("t2_s0", 0, 0, 0);
        chk_slot("t2_s1", 1, 1, 32);
        cycle();
        drive(2'b01, 1'b1, 2'b00, 0, 0, 2'b00, 1'b0);
        #1;
        chk_slot("t2_next", 0, 1, 33);
        cycle();

        // 3: drain to one entry, then all-or-nothing refusal
        do_reset();
        for (int c = 0; c < 15; c++) begin
            drive(2'b11, 1'b1, 2'b00, 0, 0, 2'b00, 1'b0);
            cycle();
        end
        drive(2'b01, 1'b1, 2'b00, 0, 0, 2'b00, 1'b0);
        cycle();
        chk("t3_count1", int'(free_count), 1);
        drive(2'b11, 1'b1, 2'b00, 0, 0, 2'b00, 1'b0);
        #1;
        chk("t3_ready_low", int'(alloc_ready), 0);
        cycle();
        chk("t3_head_held", int'(free_count), 1);
        drive(2'b01, 1'b1, 2'b00, 0, 0, 2'b00, 1'b0);
        #1;
        chk_slot("t3_last", 0, 1, 63);
        cycle();
        chk("t3_empty", int'(free_count), 0);

        // 4: frees at empty are not visible the same cycle
        drive(2'b11, 1'b1, 2'b11, 40, 41, 2'b00, 1'b0);
        #1;
        chk("t4_no_bypass", int'(alloc_ready), 0);
        cycle();
        drive(2'b11, 1'b1, 2'b00, 0, 0, 2'b00, 1'b0);
        #1;
        chk("t4_count", int'(free_count), 2);
        chk_slot("t4_s0", 0, 1, 40);
        chk_slot("t4_s1", 1, 1, 41);
        cycle();

        // 5a: flush rolls head back to the committed head
        do_reset();
        for (int c = 0; c < 2; c++) begin
            drive(2'b11, 1'b1, 2'b00, 0, 0, 2'b00, 1'b0);
            cycle();
        end
        drive(2'b00, 1'b0, 2'b00, 0, 0, 2'b11, 1'b0);
        cycle();
        drive(2'b11, 1'b1, 2'b00, 0, 0, 2'b00, 1'b1);
        cycle();
        drive(2'b01, 1'b0, 2'b00, 0, 0, 2'b00, 1'b0);
        #1;
        chk("t5a_count", int'(free_count), 30);
        chk_slot("t5a_s0", 0, 1, 34);
        cycle();

        // 5b: commit in the flush cycle counts toward the rollback target
        do_reset();
        for (int c = 0; c < 2; c++) begin
            drive(2'b11, 1'b1, 2'b00, 0, 0, 2'b00, 1'b0);
            cycle();
        end
        drive(2'b00, 1'b0, 2'b00, 0, 0, 2'b11, 1'b0);
        cycle();
        drive(2'b00, 1'b0, 2'b00, 0, 0, 2'b01, 1'b1);
        cycle();
        drive(2'b01, 1'b0, 2'b00, 0, 0, 2'b00, 1'b0);
        #1;
        chk("t5b_count", int'(free_count), 29);
        chk_slot("t5b_s0", 0, 1, 35);
        cycle();

        // 6: random traffic with flushes and mid-stream resets
        do_reset();
        for (int c = 0; c < 900; c++) begin
            logic [1:0] req, fv, ca;
            logic       en, fl;
            int         ids[2];
            int         budget;
            int         pool[$];
            if (c == 300 || c == 600) do_reset();
            req    = 2'($urandom_range(0, 3));
            en     = ($urandom_range(0, 3) != 0);
            fl     = ($urandom_range(0, 31) == 0);
            ca     = 2'b00;
            budget = spec_q.size();
            for (int p = 0; p < FREE_WIDTH; p++) begin
                if (budget > 0 && $urandom_range(0, 1) == 1) begin
                    ca[p] = 1'b1;
                    budget--;
                end
            end
            fv   = 2'b00;
            ids  = '{0, 0};
            pool = used_q;
            for (int p = 0; p < FREE_WIDTH; p++) begin
                if (pool.size() > NUM_CREG && $urandom_range(0, 2) != 0) begin
                    int k;
                    k      = $urandom_range(0, pool.size() - 1);
                    ids[p] = pool[k];
                    pool.delete(k);
                    fv[p]  = 1'b1;
                end
            end
            drive(req, en, fv, ids[0], ids[1], ca, fl);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
